// File: rtl/mem_bus_access.sv
// MEM-stage load/store unit: decodes memory aluops, runs one Wishbone-style bus cycle,
// aligns big-endian byte lanes, extends loads and flags misalignment or bus timeout.
//
// state | meaning
// IDLE  | no bus cycle; issue one when a legal memory op arrives
// BUSY  | cyc/stb asserted, waiting for ack or timeout
// DONE  | result (or bus error) presented to MEM/WB until it is accepted
module mem_bus_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [5:0]  stall,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] excepttype_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        addr_err_o,
    output logic        bus_err_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic          is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic          is_mem, misaligned, access;
    logic [3:0]    sel_nxt;
    logic [31:0]   dat_nxt;
    logic [31:0]   rd_buf;
    logic [31:0]   ld_ext;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          err_flag;
    logic [CW-1:0] cnt, cnt_inc;
    logic          timeout_hit;
    logic          stall_unused;

    assign stall_unused = ^{stall[5], stall[3:0]};

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (aluop_i)
            OP_LB:   begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU:  begin is_load = 1'b1; is_byte = 1'b1; end
            OP_LH:   begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW:   begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
    assign access     = is_mem && (excepttype_i == '0) && !misaligned;

    always_comb begin
        sel_nxt = 4'b1111;
        dat_nxt = reg2_i;
        if (is_byte) begin
            sel_nxt = 4'b1000 >> mem_addr_i[1:0];
            dat_nxt = {4{reg2_i[7:0]}};
        end else if (is_half) begin
            sel_nxt = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            dat_nxt = {2{reg2_i[15:0]}};
        end
    end

    // Big-endian: byte offset 0 lives in bits 31:24.
    always_comb begin
        case (mem_addr_i[1:0])
            2'd0:    ld_byte = rd_buf[31:24];
            2'd1:    ld_byte = rd_buf[23:16];
            2'd2:    ld_byte = rd_buf[15:8];
            default: ld_byte = rd_buf[7:0];
        endcase
        ld_half = mem_addr_i[1] ? rd_buf[15:0] : rd_buf[31:16];
        if (is_byte)
            ld_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
        else if (is_half)
            ld_ext = {{16{is_signed & ld_half[15]}}, ld_half};
        else
            ld_ext = rd_buf;
    end

    assign cnt_inc     = cnt + CW'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_adr_o <= '0;
            bus_dat_o <= '0;
            bus_sel_o <= '0;
            bus_we_o  <= 1'b0;
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            cnt       <= '0;
            rd_buf    <= '0;
            err_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                bus_cyc_o <= 1'b0;
                bus_stb_o <= 1'b0;
                bus_we_o  <= 1'b0;
                err_flag  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (access) begin
                        bus_adr_o <= {mem_addr_i[31:2], 2'b00};
                        bus_dat_o <= dat_nxt;
                        bus_sel_o <= sel_nxt;
                        bus_we_o  <= is_store;
                        bus_cyc_o <= 1'b1;
                        bus_stb_o <= 1'b1;
                        cnt       <= '0;
                        err_flag  <= 1'b0;
                    end
                    BUSY: begin
                        cnt <= cnt_inc;
                        if (bus_ack_i) begin
                            rd_buf    <= bus_dat_i;
                            bus_cyc_o <= 1'b0;
                            bus_stb_o <= 1'b0;
                            bus_we_o  <= 1'b0;
                        end else if (timeout_hit) begin
                            bus_cyc_o <= 1'b0;
                            bus_stb_o <= 1'b0;
                            bus_we_o  <= 1'b0;
                            err_flag  <= 1'b1;
                        end
                    end
                    DONE: if (!stall[4]) err_flag <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (access && !flush) state_nxt = BUSY;
            BUSY: begin
                if (flush)
                    state_nxt = IDLE;
                else if (bus_ack_i || timeout_hit)
                    state_nxt = DONE;
            end
            DONE: if (flush || !stall[4]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stallreq_o = 1'b0;
        addr_err_o = 1'b0;
        bus_err_o  = 1'b0;
        badvaddr_o = '0;
        if (is_mem && (excepttype_i == '0) && misaligned) begin
            addr_err_o = 1'b1;
            badvaddr_o = mem_addr_i;
            wreg_o     = 1'b0;
        end
        case (state)
            IDLE: if (access) begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
            end
            BUSY: begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
            end
            DONE: begin
                if (is_load) begin
                    wdata_o = ld_ext;
                    wreg_o  = wreg_i;
                end else begin
                    wreg_o = 1'b0;
                end
                if (err_flag) begin
                    bus_err_o  = 1'b1;
                    badvaddr_o = mem_addr_i;
                    wreg_o     = 1'b0;
                end
            end
            default: ;
        endcase
        if (flush) begin
            wreg_o     = 1'b0;
            stallreq_o = 1'b0;
        end
        if (rst) begin
            wd_o       = '0;
            wreg_o     = 1'b0;
            wdata_o    = '0;
            stallreq_o = 1'b0;
            addr_err_o = 1'b0;
            bus_err_o  = 1'b0;
            badvaddr_o = '0;
        end
    end
endmodule
